// File: rtl/risc_core_mc_if.sv
// Bus bundle of the multi-cycle RISC core: instruction ROM port and
// data-memory request/acknowledge port.
//   imem_addr  : instruction address (core -> ROM)
//   imem_rdata : instruction word, registered by the ROM (ROM -> core)
//   dmem_req   : data transfer request, held until acknowledged
//   dmem_we    : 1 = write, 0 = read
//   dmem_addr  : data address
//   dmem_wdata : store data
//   dmem_rdata : load data, sampled in the acknowledge cycle
//   dmem_ack   : transfer complete
interface risc_core_mc_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/risc_core_mc.sv
// Multi-cycle RISC core: FETCH/DECODE/EXEC/MEM/WB state machine, four
// registers with R0 hardwired to zero, stalling data-memory handshake and
// a memory-mapped I/O port at the all-ones data address.
//   clk            : clock
//   reset          : asynchronous, active-low reset
//   bus            : instruction ROM and data-memory port (master side)
//   ext_data_in    : I/O input, sampled in EXEC of an I/O load
//   data_out       : registered I/O output, updated by an I/O store
//   data_out_valid : one-cycle pulse after each I/O store
//   halted         : high once HALT has executed, until reset
module risc_core_mc #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    risc_core_mc_if.master        bus,
    input  logic [DATA_W-1:0]     ext_data_in,
    output logic [DATA_W-1:0]     data_out,
    output logic                  data_out_valid,
    output logic                  halted
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD   = 3'd0;
    localparam logic [2:0] OP_SUB   = 3'd1;
    localparam logic [2:0] OP_LOAD  = 3'd2;
    localparam logic [2:0] OP_STORE = 3'd3;
    localparam logic [2:0] OP_JUMP  = 3'd4;
    localparam logic [2:0] OP_BEQZ  = 3'd5;
    localparam logic [2:0] OP_ADDI  = 3'd6;
    localparam logic [2:0] OP_HALT  = 3'd7;

    localparam logic [ADDR_W-1:0] IO_ADDR = {ADDR_W{1'b1}};

    state_t            state_r, next_state_s;
    logic [ADDR_W-1:0] pc_r;
    logic [15:0]       ir_r;
    logic [DATA_W-1:0] r1_r, r2_r, r3_r;
    logic [DATA_W-1:0] wb_data_r;
    logic              req_r, we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic [DATA_W-1:0] data_out_r;
    logic              valid_r;
    logic              halted_r;

    logic [2:0]        op_s;
    logic [1:0]        rd_s, rs1_s, rs2_s;
    logic [7:0]        imm8_s;
    logic [DATA_W-1:0] imm_d_s;
    logic [ADDR_W-1:0] imm_a_s;
    logic [DATA_W-1:0] rs1_val_s, rs2_val_s, rd_val_s;
    logic [ADDR_W-1:0] ea_s;
    logic              io_hit_s;
    logic [ADDR_W-1:0] pc_next_s;
    logic [DATA_W-1:0] alu_s;

    // Register-file read port; index 0 is the hardwired zero register.
    function automatic logic [DATA_W-1:0] reg_read(
        input logic [1:0]        idx,
        input logic [DATA_W-1:0] v1,
        input logic [DATA_W-1:0] v2,
        input logic [DATA_W-1:0] v3
    );
        case (idx)
            2'd1:    return v1;
            2'd2:    return v2;
            2'd3:    return v3;
            default: return {DATA_W{1'b0}};
        endcase
    endfunction

    assign op_s      = ir_r[15:13];
    assign rd_s      = ir_r[12:11];
    assign rs1_s     = ir_r[10:9];
    assign rs2_s     = ir_r[8:7];
    assign imm8_s    = ir_r[7:0];
    assign imm_d_s   = DATA_W'(imm8_s);
    assign imm_a_s   = ADDR_W'(imm8_s);
    assign rs1_val_s = reg_read(rs1_s, r1_r, r2_r, r3_r);
    assign rs2_val_s = reg_read(rs2_s, r1_r, r2_r, r3_r);
    assign rd_val_s  = reg_read(rd_s, r1_r, r2_r, r3_r);
    assign ea_s      = ADDR_W'(rs1_val_s) + imm_a_s;
    assign io_hit_s  = (ea_s == IO_ADDR);

    // ALU result and next PC for the instruction held in IR.
    always_comb begin
        alu_s     = {DATA_W{1'b0}};
        pc_next_s = pc_r + ADDR_W'(1'b1);
        case (op_s)
            OP_ADD:  alu_s = rs1_val_s + rs2_val_s;
            OP_SUB:  alu_s = rs1_val_s - rs2_val_s;
            OP_ADDI: alu_s = rs1_val_s + imm_d_s;
            default: alu_s = {DATA_W{1'b0}};
        endcase
        if (op_s == OP_JUMP) begin
            pc_next_s = imm_a_s;
        end else if ((op_s == OP_BEQZ) && (rs1_val_s == {DATA_W{1'b0}})) begin
            pc_next_s = imm_a_s;
        end else begin
            pc_next_s = pc_r + ADDR_W'(1'b1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; I/O-address accesses bypass MEM entirely.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_FETCH:  next_state_s = S_DECODE;
            S_DECODE: next_state_s = S_EXEC;
            S_EXEC: begin
                case (op_s)
                    OP_ADD, OP_SUB, OP_ADDI: next_state_s = S_WB;
                    OP_LOAD:   next_state_s = io_hit_s ? S_WB : S_MEM;
                    OP_STORE:  next_state_s = io_hit_s ? S_FETCH : S_MEM;
                    OP_JUMP, OP_BEQZ: next_state_s = S_FETCH;
                    OP_HALT:   next_state_s = S_HALTED;
                    default:   next_state_s = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ack) begin
                    next_state_s = (op_s == OP_LOAD) ? S_WB : S_FETCH;
                end else begin
                    next_state_s = S_MEM;
                end
            end
            S_WB:     next_state_s = S_FETCH;
            S_HALTED: next_state_s = S_HALTED;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // Datapath: PC, IR, register file, bus request and I/O registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_r       <= {ADDR_W{1'b0}};
            ir_r       <= 16'h0000;
            r1_r       <= {DATA_W{1'b0}};
            r2_r       <= {DATA_W{1'b0}};
            r3_r       <= {DATA_W{1'b0}};
            wb_data_r  <= {DATA_W{1'b0}};
            req_r      <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= {ADDR_W{1'b0}};
            wdata_r    <= {DATA_W{1'b0}};
            data_out_r <= {DATA_W{1'b0}};
            valid_r    <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                S_DECODE: ir_r <= bus.imem_rdata;
                S_EXEC: begin
                    if (op_s != OP_HALT) begin
                        pc_r <= pc_next_s;
                    end
                    case (op_s)
                        OP_ADD, OP_SUB, OP_ADDI: wb_data_r <= alu_s;
                        OP_LOAD: begin
                            if (io_hit_s) begin
                                wb_data_r <= ext_data_in;
                            end else begin
                                req_r   <= 1'b1;
                                we_r    <= 1'b0;
                                addr_r  <= ea_s;
                                wdata_r <= {DATA_W{1'b0}};
                            end
                        end
                        OP_STORE: begin
                            if (io_hit_s) begin
                                data_out_r <= rd_val_s;
                                valid_r    <= 1'b1;
                            end else begin
                                req_r   <= 1'b1;
                                we_r    <= 1'b1;
                                addr_r  <= ea_s;
                                wdata_r <= rd_val_s;
                            end
                        end
                        OP_HALT: halted_r <= 1'b1;
                        default: halted_r <= halted_r;
                    endcase
                end
                S_MEM: begin
                    // Bus fields stay constant until the acknowledge cycle.
                    if (bus.dmem_ack) begin
                        req_r   <= 1'b0;
                        we_r    <= 1'b0;
                        addr_r  <= {ADDR_W{1'b0}};
                        wdata_r <= {DATA_W{1'b0}};
                        if (op_s == OP_LOAD) begin
                            wb_data_r <= bus.dmem_rdata;
                        end
                    end
                end
                S_WB: begin
                    // Writes to R0 are dropped by the default branch.
                    case (rd_s)
                        2'd1:    r1_r <= wb_data_r;
                        2'd2:    r2_r <= wb_data_r;
                        2'd3:    r3_r <= wb_data_r;
                        default: r1_r <= r1_r;
                    endcase
                end
                default: halted_r <= halted_r;
            endcase
        end
    end

    assign bus.imem_addr  = pc_r;
    assign bus.dmem_req   = req_r;
    assign bus.dmem_we    = we_r;
    assign bus.dmem_addr  = addr_r;
    assign bus.dmem_wdata = wdata_r;
    assign data_out       = data_out_r;
    assign data_out_valid = valid_r;
    assign halted         = halted_r;
endmodule
